stack_cpu_controller: RTL and testbench

- Multi-cycle FSM control unit for the stack-CPU datapath: PC incrementer, main stack pointer (MSP, grows up), return stack pointer (RSP, grows down), dual-port memory and the ValA/ValB/IR registers.
- Decodes IR[15:12] and drives every datapath strobe and select, one micro-step per CLK.
- Instantiated beside the datapath integration; ALU function select comes from here, ALU result returns on the datapath's ResOut.

---
 rtl/stack_cpu_pkg.sv | 32 +++
 rtl/stack_cpu_ctrl_decode.sv | 115 +++++++++++
 rtl/stack_cpu_controller.sv | 122 ++++++++++++
 tb/tb_stack_cpu_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared opcodes, controller state encoding and datapath select constants for the stack CPU.
package stack_cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_ALU   = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_CALL  = 4'd6;
  localparam logic [3:0] OP_RET   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [1:0] MD1_PC   = 2'd0;
  localparam logic [1:0] MD1_MSP  = 2'd1;
  localparam logic [1:0] MD2_MSP  = 2'd0;
  localparam logic [1:0] MD2_RSP  = 2'd1;
  localparam logic [2:0] MDAT_PC  = 3'd0;
  localparam logic [2:0] MDAT_RES = 3'd1;
  localparam logic [2:0] MDAT_IMM = 3'd2;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE,
    S_PSH_W, S_PSH_I, S_POP_D,
    S_A_D1, S_A_RB, S_A_D2, S_A_RA, S_A_W, S_A_I,
    S_J_PC, S_BZ_D, S_BZ_R, S_BZ_T,
    S_C_D, S_C_W, S_C_PC,
    S_R_R, S_R_I, S_R_PC,
    S_HALT
  } state_e;

endpackage

// File: rtl/stack_cpu_ctrl_decode.sv
// Combinational state-to-strobe table; every output is a function of the current micro-step only
// (plus the branch flag in BZ_T and the ALU function field in A_W).
module stack_cpu_ctrl_decode
  import stack_cpu_pkg::*;
#(
  parameter int FNW = 3
) (
  input  state_e         state_i,
  input  logic [FNW-1:0] fn_i,
  input  logic           zero_i,
  output logic           msp_write_o,
  output logic           msp_pop_o,
  output logic           rsp_write_o,
  output logic           rsp_pop_o,
  output logic           pc_write_o,
  output logic           pc_source_o,
  output logic           pc_add_o,
  output logic           vala_write_o,
  output logic           valb_write_o,
  output logic           ir_write_o,
  output logic           mem_read1_o,
  output logic           mem_read2_o,
  output logic           mem_write1_o,
  output logic           mem_write2_o,
  output logic [1:0]     mem_dst1_o,
  output logic [1:0]     mem_dst2_o,
  output logic [2:0]     mem_data_o,
  output logic [FNW-1:0] alu_op_o,
  output logic           halted_o
);

  always_comb begin
    msp_write_o  = 1'b0;
    msp_pop_o    = 1'b0;
    rsp_write_o  = 1'b0;
    rsp_pop_o    = 1'b0;
    pc_write_o   = 1'b0;
    pc_source_o  = 1'b0;
    pc_add_o     = 1'b0;
    vala_write_o = 1'b0;
    valb_write_o = 1'b0;
    ir_write_o   = 1'b0;
    mem_read1_o  = 1'b0;
    mem_read2_o  = 1'b0;
    mem_write1_o = 1'b0;
    mem_write2_o = 1'b0;
    mem_dst1_o   = MD1_PC;
    mem_dst2_o   = MD2_MSP;
    mem_data_o   = MDAT_PC;
    alu_op_o     = '0;
    halted_o     = 1'b0;
    unique case (state_i)
      S_FETCH: begin
        mem_read1_o = 1'b1;
        mem_dst1_o  = MD1_PC;
        ir_write_o  = 1'b1;
        pc_write_o  = 1'b1;
      end
      S_PSH_W: begin
        mem_write2_o = 1'b1;
        mem_dst2_o   = MD2_MSP;
        mem_data_o   = MDAT_IMM;
      end
      S_PSH_I, S_A_I: msp_write_o = 1'b1;
      S_POP_D, S_A_D1, S_A_D2, S_BZ_D: begin
        msp_write_o = 1'b1;
        msp_pop_o   = 1'b1;
      end
      S_A_RB: begin
        mem_read2_o  = 1'b1;
        valb_write_o = 1'b1;
      end
      S_A_RA, S_BZ_R: begin
        mem_read2_o  = 1'b1;
        vala_write_o = 1'b1;
      end
      S_A_W: begin
        mem_write2_o = 1'b1;
        mem_data_o   = MDAT_RES;
        alu_op_o     = fn_i;
      end
      S_J_PC, S_C_PC: begin
        pc_write_o = 1'b1;
        pc_add_o   = 1'b1;
      end
      // Branch not taken leaves the PC alone: no strobe at all in this step.
      S_BZ_T: begin
        pc_write_o = zero_i;
        pc_add_o   = zero_i;
      end
      S_C_D: rsp_write_o = 1'b1;
      S_C_W: begin
        mem_write2_o = 1'b1;
        mem_dst2_o   = MD2_RSP;
        mem_data_o   = MDAT_PC;
      end
      S_R_R: begin
        mem_read2_o  = 1'b1;
        mem_dst2_o   = MD2_RSP;
        vala_write_o = 1'b1;
      end
      S_R_I: begin
        rsp_write_o = 1'b1;
        rsp_pop_o   = 1'b1;
      end
      S_R_PC: begin
        pc_write_o  = 1'b1;
        pc_source_o = 1'b1;
      end
      S_HALT: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_cpu_controller.sv
// Multi-cycle control unit for the stack CPU: state register, opcode sequencing and sticky
// illegal-opcode flag. Strobes come from the combinational decode table.
module stack_cpu_controller
  import stack_cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int FNW = 3
) (
  input  logic           CLK,
  input  logic           Reset_n,
  input  logic           Run,
  input  logic [15:0]    IR,
  input  logic           ValAZero,
  output logic           MSPWrite,
  output logic           MSPPop,
  output logic           RSPWrite,
  output logic           RSPPop,
  output logic           PCWrite,
  output logic           PCSource,
  output logic           PCAdd,
  output logic           ValAWrite,
  output logic           ValBWrite,
  output logic           IRWrite,
  output logic           MemRead1,
  output logic           MemRead2,
  output logic           MemWrite1,
  output logic           MemWrite2,
  output logic [1:0]     MemDst1,
  output logic [1:0]     MemDst2,
  output logic [2:0]     MemData,
  output logic [FNW-1:0] ALUOp,
  output logic           Halted,
  output logic           Illegal
);

  state_e         state_q, state_d;
  logic           illegal_q, illegal_d;
  logic [OPW-1:0] opcode;
  logic           unused_ir;

  assign opcode    = IR[15:16-OPW];
  assign unused_ir = ^IR[15-OPW:FNW];
  assign Illegal   = illegal_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE:   if (Run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_NOP:   state_d = S_FETCH;
          OP_PUSHI: state_d = S_PSH_W;
          OP_POP:   state_d = S_POP_D;
          OP_ALU:   state_d = S_A_D1;
          OP_JMP:   state_d = S_J_PC;
          OP_BZ:    state_d = S_BZ_D;
          OP_CALL:  state_d = S_C_D;
          OP_RET:   state_d = S_R_R;
          OP_HALT:  state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_PSH_W:  state_d = S_PSH_I;
      S_A_D1:   state_d = S_A_RB;
      S_A_RB:   state_d = S_A_D2;
      S_A_D2:   state_d = S_A_RA;
      S_A_RA:   state_d = S_A_W;
      S_A_W:    state_d = S_A_I;
      S_BZ_D:   state_d = S_BZ_R;
      S_BZ_R:   state_d = S_BZ_T;
      S_C_D:    state_d = S_C_W;
      S_C_W:    state_d = S_C_PC;
      S_R_R:    state_d = S_R_I;
      S_R_I:    state_d = S_R_PC;
      S_PSH_I, S_POP_D, S_A_I, S_J_PC, S_BZ_T, S_C_PC, S_R_PC: state_d = S_FETCH;
      // Only reset leaves HALT; Run is deliberately ignored here.
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  stack_cpu_ctrl_decode #(.FNW(FNW)) u_decode (
    .state_i      (state_q),
    .fn_i         (IR[FNW-1:0]),
    .zero_i       (ValAZero),
    .msp_write_o  (MSPWrite),
    .msp_pop_o    (MSPPop),
    .rsp_write_o  (RSPWrite),
    .rsp_pop_o    (RSPPop),
    .pc_write_o   (PCWrite),
    .pc_source_o  (PCSource),
    .pc_add_o     (PCAdd),
    .vala_write_o (ValAWrite),
    .valb_write_o (ValBWrite),
    .ir_write_o   (IRWrite),
    .mem_read1_o  (MemRead1),
    .mem_read2_o  (MemRead2),
    .mem_write1_o (MemWrite1),
    .mem_write2_o (MemWrite2),
    .mem_dst1_o   (MemDst1),
    .mem_dst2_o   (MemDst2),
    .mem_data_o   (MemData),
    .alu_op_o     (ALUOp),
    .halted_o     (Halted)
  );

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Self-checking bench: per-cycle strobe vectors expected from instruction semantics, plus
// net pointer / PC-write effects per instruction, under randomized programs and Run toggling.
module tb_stack_cpu_controller;

  logic        CLK = 1'b0;
  logic        Reset_n, Run, ValAZero;
  logic [15:0] IR;
  logic MSPWrite, MSPPop, RSPWrite, RSPPop, PCWrite, PCSource, PCAdd;
  logic ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0] MemDst1, MemDst2;
  logic [2:0] MemData, ALUOp;
  logic Halted, Illegal;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic msp_w, msp_pop, rsp_w, rsp_pop, pc_w, pc_src, pc_add;
    logic vala_w, valb_w, ir_w, mr1, mr2, mw1, mw2;
    logic [1:0] md1, md2;
    logic [2:0] mdat, aluop;
    logic halted, illegal;
  } outs_t;

  outs_t obs;
  assign obs = {MSPWrite, MSPPop, RSPWrite, RSPPop, PCWrite, PCSource, PCAdd,
                ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
                MemDst1, MemDst2, MemData, ALUOp, Halted, Illegal};

  always #5 CLK = ~CLK;

  stack_cpu_controller dut (
    .CLK(CLK), .Reset_n(Reset_n), .Run(Run), .IR(IR), .ValAZero(ValAZero),
    .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .ALUOp(ALUOp),
    .Halted(Halted), .Illegal(Illegal)
  );

  // Micro-operations described by what they do to the machine.
  function automatic outs_t idle_v();
    return '0;
  endfunction
  function automatic outs_t fetch_v();
    outs_t o = '0;
    o.mr1 = 1'b1; o.md1 = 2'd0; o.ir_w = 1'b1; o.pc_w = 1'b1;
    return o;
  endfunction
  function automatic outs_t msp_v(bit pop);
    outs_t o = '0;
    o.msp_w = 1'b1; o.msp_pop = pop;
    return o;
  endfunction
  function automatic outs_t rsp_v(bit pop);
    outs_t o = '0;
    o.rsp_w = 1'b1; o.rsp_pop = pop;
    return o;
  endfunction
  function automatic outs_t read_v(bit from_rsp, bit to_a);
    outs_t o = '0;
    o.mr2 = 1'b1; o.md2 = from_rsp ? 2'd1 : 2'd0;
    if (to_a) o.vala_w = 1'b1; else o.valb_w = 1'b1;
    return o;
  endfunction
  function automatic outs_t write_v(bit to_rsp, logic [2:0] src, logic [2:0] fn);
    outs_t o = '0;
    o.mw2 = 1'b1; o.md2 = to_rsp ? 2'd1 : 2'd0; o.mdat = src; o.aluop = fn;
    return o;
  endfunction
  function automatic outs_t pc_v(bit src, bit add);
    outs_t o = '0;
    o.pc_w = 1'b1; o.pc_src = src; o.pc_add = add;
    return o;
  endfunction
  function automatic outs_t halt_v(bit ill);
    outs_t o = '0;
    o.halted = 1'b1; o.illegal = ill;
    return o;
  endfunction

  // Runs one legal non-halt instruction starting from a FETCH cycle; ends in the next FETCH.
  task automatic run_instr(input string name, input logic [15:0] ir, input logic z);
    outs_t q[$];
    int msp_d, rs_d, pcw, exp_msp, exp_rs, exp_pcw;
    int op;
    op = int'(ir[15:12]);
    IR = ir;
    ValAZero = z;
    q.push_back(fetch_v());
    q.push_back(idle_v());
    case (op)
      1: begin q.push_back(write_v(0, 3'd2, 3'd0)); q.push_back(msp_v(0)); end
      2: q.push_back(msp_v(1));
      3: begin
        q.push_back(msp_v(1)); q.push_back(read_v(0, 0));
        q.push_back(msp_v(1)); q.push_back(read_v(0, 1));
        q.push_back(write_v(0, 3'd1, ir[2:0])); q.push_back(msp_v(0));
      end
      4: q.push_back(pc_v(0, 1));
      5: begin
        q.push_back(msp_v(1)); q.push_back(read_v(0, 1));
        q.push_back(z ? pc_v(0, 1) : idle_v());
      end
      6: begin q.push_back(rsp_v(0)); q.push_back(write_v(1, 3'd0, 3'd0)); q.push_back(pc_v(0, 1)); end
      7: begin q.push_back(read_v(1, 1)); q.push_back(rsp_v(1)); q.push_back(pc_v(1, 0)); end
      default: ;
    endcase
    msp_d = 0; rs_d = 0; pcw = 0;
    foreach (q[i]) begin
      checks++;
      if (obs !== q[i]) begin
        failures++;
        $display("FAIL %s step%0d ir=%h: got %h expected %h", name, i, ir, obs, q[i]);
      end
      if (MSPWrite === 1'b1) msp_d += (MSPPop === 1'b1) ? -1 : 1;
      if (RSPWrite === 1'b1) rs_d += (RSPPop === 1'b1) ? -1 : 1;
      if (PCWrite === 1'b1) pcw++;
      Run = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    exp_msp = (op == 1) ? 1 : (op == 2 || op == 3 || op == 5) ? -1 : 0;
    exp_rs  = (op == 6) ? 1 : (op == 7) ? -1 : 0;
    exp_pcw = 1 + ((op == 4 || op == 6 || op == 7) ? 1 : 0) + ((op == 5 && z) ? 1 : 0);
    checks++;
    if (msp_d !== exp_msp) begin
      failures++;
      $display("FAIL %s msp_net ir=%h: got %0d expected %0d", name, ir, msp_d, exp_msp);
    end
    checks++;
    if (rs_d !== exp_rs) begin
      failures++;
      $display("FAIL %s rsp_net ir=%h: got %0d expected %0d", name, ir, rs_d, exp_rs);
    end
    checks++;
    if (pcw !== exp_pcw) begin
      failures++;
      $display("FAIL %s pc_writes ir=%h: got %0d expected %0d", name, ir, pcw, exp_pcw);
    end
  endtask

  task automatic restart();
    Reset_n = 1'b0;
    Run = 1'b1;
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Run = 1'b1; IR = 16'h1ABC; ValAZero = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (obs !== idle_v()) begin
        failures++;
        $display("FAIL reset_outputs: got %h expected %h", obs, idle_v());
      end
    end
    Run = 1'b0;
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (obs !== idle_v()) begin
        failures++;
        $display("FAIL idle_hold: got %h expected %h", obs, idle_v());
      end
    end
    Run = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== fetch_v()) begin
      failures++;
      $display("FAIL first_fetch: got %h expected %h", obs, fetch_v());
    end
  endtask

  task automatic test_pushi();
    run_instr("pushi", 16'h1ABC, 1'b0);
  endtask

  task automatic test_alu();
    run_instr("alu", 16'h3002, 1'b0);
    run_instr("alu_fn7", 16'h3FFF, 1'b1);
  endtask

  task automatic test_bz();
    run_instr("bz_taken", 16'h5004, 1'b1);
    run_instr("bz_not_taken", 16'h5004, 1'b0);
  endtask

  task automatic test_call_ret();
    run_instr("call", 16'h6010, 1'b0);
    run_instr("ret", 16'h7000, 1'b1);
  endtask

  task automatic test_random_program();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ir;
      ir = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
      run_instr("random", ir, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_alu();
    outs_t q[$];
    IR = 16'h3005; ValAZero = 1'b0;
    q.push_back(fetch_v()); q.push_back(idle_v()); q.push_back(msp_v(1));
    q.push_back(read_v(0, 0)); q.push_back(msp_v(1)); q.push_back(read_v(0, 1));
    foreach (q[i]) begin
      checks++;
      if (obs !== q[i]) begin
        failures++;
        $display("FAIL alu_prefix step%0d: got %h expected %h", i, obs, q[i]);
      end
      if (i < q.size() - 1) @(negedge CLK);
    end
    Reset_n = 1'b0;
    Run = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== idle_v()) begin
      failures++;
      $display("FAIL reset_mid_alu: got %h expected %h", obs, idle_v());
    end
    Reset_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs !== fetch_v()) begin
      failures++;
      $display("FAIL refetch_after_abort: got %h expected %h", obs, fetch_v());
    end
  endtask

  task automatic test_halt_or_illegal(input string name, input logic [15:0] ir, input bit ill);
    IR = ir;
    checks++;
    if (obs !== fetch_v()) begin
      failures++;
      $display("FAIL %s fetch: got %h expected %h", name, obs, fetch_v());
    end
    @(negedge CLK);
    checks++;
    if (obs !== idle_v()) begin
      failures++;
      $display("FAIL %s decode: got %h expected %h", name, obs, idle_v());
    end
    for (int c = 0; c < 6; c++) begin
      Run = c[0];
      @(negedge CLK);
      checks++;
      if (obs !== halt_v(ill)) begin
        failures++;
        $display("FAIL %s held%0d: got %h expected %h", name, c, obs, halt_v(ill));
      end
    end
    Reset_n = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== idle_v()) begin
      failures++;
      $display("FAIL %s reset_clear: got %h expected %h", name, obs, idle_v());
    end
    Reset_n = 1'b1;
    Run = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pushi();
    test_alu();
    test_bz();
    test_call_ret();
    test_random_program();
    test_reset_mid_alu();
    test_halt_or_illegal("halt", 16'hF123, 1'b0);
    test_halt_or_illegal("illegal9", 16'h9000, 1'b1);
    for (int k = 0; k < 3; k++)
      test_halt_or_illegal("illegal_rand", {4'($urandom_range(8, 14)), 12'($urandom)}, 1'b1);
    restart();
    run_instr("after_illegal", 16'h2000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
